// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and shared-ALU signals of the two-port ALU arbiter.
interface alu_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [3:0]  req0_fn, req1_fn;
    logic        req0_lock, req1_lock;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_res, rsp1_res;
    logic        alu_clk_en;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_fn;
    logic [31:0] alu_res;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
        input  req0_fn, req1_fn, req0_lock, req1_lock, alu_res,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_res, rsp1_res,
        output alu_clk_en, alu_a, alu_b, alu_fn
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
        output req0_fn, req1_fn, req0_lock, req1_lock, alu_res,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_res, rsp1_res,
        input  alu_clk_en, alu_a, alu_b, alu_fn
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters with
// round-robin or fixed-priority arbitration, grant locking and 1-cycle responses.
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   tag_v_q, tag_v_d;
    logic   tag_id_q, tag_id_d;
    logic   gnt, gnt_v, hs, gnt_lock;

    always_comb begin
        gnt   = 1'b0;
        gnt_v = 1'b0;
        case (state_q)
            LOCK0: begin
                gnt   = 1'b0;
                gnt_v = bus.req0_valid;
            end
            LOCK1: begin
                gnt   = 1'b1;
                gnt_v = bus.req1_valid;
            end
            default: begin
                gnt   = (bus.req0_valid && bus.req1_valid) ? ((RR_EN != 0) && ptr_q) : bus.req1_valid;
                gnt_v = bus.req0_valid || bus.req1_valid;
            end
        endcase
        // rst_n gates the handshake so every output drops the instant reset asserts
        hs       = gnt_v && rst_n;
        gnt_lock = gnt ? bus.req1_lock : bus.req0_lock;
        state_d  = state_q;
        if (hs && state_q == ARB && gnt_lock)
            state_d = gnt ? LOCK1 : LOCK0;
        else if (hs && state_q != ARB && !gnt_lock)
            state_d = ARB;
        ptr_d    = hs ? !gnt : ptr_q;
        tag_v_d  = hs;
        tag_id_d = hs ? gnt : tag_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            ptr_q    <= 1'b0;
            tag_v_q  <= 1'b0;
            tag_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
        end
    end

    assign bus.req0_ready = hs && !gnt;
    assign bus.req1_ready = hs && gnt;
    assign bus.alu_clk_en = hs;
    assign bus.alu_a      = !hs ? 32'd0 : gnt ? bus.req1_a : bus.req0_a;
    assign bus.alu_b      = !hs ? 32'd0 : gnt ? bus.req1_b : bus.req0_b;
    assign bus.alu_fn     = !hs ? 4'd0 : gnt ? bus.req1_fn : bus.req0_fn;
    assign bus.rsp0_valid = tag_v_q && !tag_id_q;
    assign bus.rsp1_valid = tag_v_q && tag_id_q;
    assign bus.rsp0_res   = (tag_v_q && !tag_id_q) ? bus.alu_res : 32'd0;
    assign bus.rsp1_res   = (tag_v_q && tag_id_q) ? bus.alu_res : 32'd0;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench; an ALU model drives alu_res and a
// lock-owner/last-winner model predicts grants and responses.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();
    alu_arbiter_if bus_f ();

    alu_arbiter #(.RR_EN(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_arbiter #(.RR_EN(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_f));

    int n_chk = 0;
    int n_pass = 0;
    int own = -1;
    int last = 1;
    bit erv0, erv1;
    logic [31:0] er0, er1;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fn);
        case (fn)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return {31'd0, $signed(a) < $signed(b)};
            4'd5: return a & b;
            4'd6: return a | b;
            4'd7: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) if (bus.alu_clk_en) bus.alu_res <= alu_f(bus.alu_a, bus.alu_b, bus.alu_fn);
    always @(posedge clk) if (bus_f.alu_clk_en) bus_f.alu_res <= alu_f(bus_f.alu_a, bus_f.alu_b, bus_f.alu_fn);

    function automatic int exp_gnt();
        bit v0, v1;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        if (own >= 0) return ((own == 0) ? v0 : v1) ? own : -1;
        if (v0 && v1) return 1 - last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic set0(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] fn, input bit lk);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_fn = fn; bus.req0_lock = lk;
    endtask

    task automatic set1(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] fn, input bit lk);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_fn = fn; bus.req1_lock = lk;
    endtask

    task automatic tick();
        int g;
        bit lk;
        g = exp_gnt();
        erv0 = (g == 0);
        erv1 = (g == 1);
        er0 = (g == 0) ? alu_f(bus.req0_a, bus.req0_b, bus.req0_fn) : 32'd0;
        er1 = (g == 1) ? alu_f(bus.req1_a, bus.req1_b, bus.req1_fn) : 32'd0;
        if (g >= 0) begin
            lk = (g == 1) ? bus.req1_lock : bus.req0_lock;
            if (own < 0 && lk) own = g;
            else if (own == g && !lk) own = -1;
            last = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        own = -1;
        last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set0(1, 32'h11, 32'h22, 0, 0);
        set1(1, 32'h33, 32'h44, 0, 0);
        #1;
        n_chk++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) $display("FAIL reset_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready); else n_pass++;
        n_chk++; if (bus.alu_clk_en !== 1'b0 || bus.alu_a !== 32'd0 || bus.alu_fn !== 4'd0) $display("FAIL reset_alu: got en=%b a=%h fn=%h want 0", bus.alu_clk_en, bus.alu_a, bus.alu_fn); else n_pass++;
        n_chk++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.rsp0_res !== 32'd0) $display("FAIL reset_rsp: got v=%b%b res=%h want 0", bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_res); else n_pass++;
        reset_dut();
    endtask

    task automatic test_basic();
        set0(1, 32'd5, 32'd3, 4'd0, 0);
        #1;
        n_chk++; if (bus.req0_ready !== 1'b1 || bus.alu_clk_en !== 1'b1) $display("FAIL basic_ready: got rdy=%b en=%b want 1 1", bus.req0_ready, bus.alu_clk_en); else n_pass++;
        n_chk++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3) $display("FAIL basic_operands: got %0d,%0d want 5,3", bus.alu_a, bus.alu_b); else n_pass++;
        tick();
        set0(0, 0, 0, 0, 0);
        n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_res !== 32'd8 || bus.rsp1_valid !== 1'b0) $display("FAIL basic_rsp: got v0=%b res=%0d v1=%b want 1 8 0", bus.rsp0_valid, bus.rsp0_res, bus.rsp1_valid); else n_pass++;
        tick();
        n_chk++; if (bus.rsp0_valid !== 1'b0 || bus.rsp0_res !== 32'd0) $display("FAIL basic_idle: got v0=%b res=%h want 0 0", bus.rsp0_valid, bus.rsp0_res); else n_pass++;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            set0(1, $urandom, $urandom, 4'($urandom_range(0, 7)), 0);
            set1(1, $urandom, $urandom, 4'($urandom_range(0, 7)), 0);
            #1;
            n_chk++; if (bus.req1_ready !== 1'(i % 2) || bus.req0_ready !== 1'(1 - i % 2)) $display("FAIL b2b_grant%0d: got %b%b want port %0d", i, bus.req1_ready, bus.req0_ready, i % 2); else n_pass++;
            tick();
            n_chk++; if (bus.rsp1_valid !== 1'(i % 2) || bus.rsp0_valid !== 1'(1 - i % 2) || bus.rsp0_res !== er0 || bus.rsp1_res !== er1) $display("FAIL b2b_rsp%0d: got v=%b%b r0=%h r1=%h want r0=%h r1=%h", i, bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_res, bus.rsp1_res, er0, er1); else n_pass++;
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 80; i++) begin
            set0($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom), $urandom_range(0, 4) == 0);
            set1($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom), $urandom_range(0, 4) == 0);
            #1;
            g = exp_gnt();
            n_chk++; if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1) || bus.alu_clk_en !== (g >= 0)) $display("FAIL rand_grant%0d: got rdy=%b%b en=%b want grant %0d", i, bus.req1_ready, bus.req0_ready, bus.alu_clk_en, g); else n_pass++;
            n_chk++; if (bus.alu_fn !== ((g == 1) ? bus.req1_fn : (g == 0) ? bus.req0_fn : 4'd0) || bus.alu_a !== ((g == 1) ? bus.req1_a : (g == 0) ? bus.req0_a : 32'd0)) $display("FAIL rand_alu%0d: got a=%h fn=%h for grant %0d", i, bus.alu_a, bus.alu_fn, g); else n_pass++;
            tick();
            n_chk++; if (bus.rsp0_valid !== erv0 || bus.rsp1_valid !== erv1 || bus.rsp0_res !== er0 || bus.rsp1_res !== er1) $display("FAIL rand_rsp%0d: got v=%b%b r0=%h r1=%h want v=%b%b r0=%h r1=%h", i, bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_res, bus.rsp1_res, erv1, erv0, er0, er1); else n_pass++;
        end
    endtask

    task automatic test_lock();
        reset_dut();
        set1(1, 32'd10, 32'd4, 4'd1, 1);
        #1;
        n_chk++; if (bus.req1_ready !== 1'b1) $display("FAIL lock_take: got %b want 1", bus.req1_ready); else n_pass++;
        tick();
        n_chk++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_res !== 32'd6) $display("FAIL lock_sub: got v=%b res=%0d want 1 6", bus.rsp1_valid, bus.rsp1_res); else n_pass++;
        set1(0, 0, 0, 0, 0);
        set0(1, $urandom, $urandom, 4'd0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (bus.req0_ready !== 1'b0 || bus.alu_clk_en !== 1'b0) $display("FAIL lock_hold%0d: got rdy0=%b en=%b want 0 0", i, bus.req0_ready, bus.alu_clk_en); else n_pass++;
            tick();
        end
        set1(1, 32'd1, 32'd4, 4'd2, 0);
        #1;
        n_chk++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) $display("FAIL lock_release: got rdy=%b%b want 10", bus.req1_ready, bus.req0_ready); else n_pass++;
        tick();
        n_chk++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_res !== 32'd16) $display("FAIL lock_shl: got v=%b res=%0d want 1 16", bus.rsp1_valid, bus.rsp1_res); else n_pass++;
        set1(0, 0, 0, 0, 0);
        #1;
        n_chk++; if (bus.req0_ready !== 1'b1) $display("FAIL lock_arb_resume: got %b want 1", bus.req0_ready); else n_pass++;
        tick();
        set0(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_fixed_priority();
        logic [31:0] a, b;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            bus_f.req0_valid = 1; bus_f.req0_a = a; bus_f.req0_b = b; bus_f.req0_fn = 4'd0; bus_f.req0_lock = 0;
            bus_f.req1_valid = 1; bus_f.req1_a = $urandom; bus_f.req1_b = $urandom; bus_f.req1_fn = 4'd1; bus_f.req1_lock = 0;
            #1;
            n_chk++; if (bus_f.req0_ready !== 1'b1 || bus_f.req1_ready !== 1'b0) $display("FAIL fixed_grant%0d: got rdy=%b%b want 01", i, bus_f.req1_ready, bus_f.req0_ready); else n_pass++;
            tick();
            n_chk++; if (bus_f.rsp0_valid !== 1'b1 || bus_f.rsp0_res !== a + b || bus_f.rsp1_valid !== 1'b0) $display("FAIL fixed_rsp%0d: got v=%b%b res=%h want 01 %h", i, bus_f.rsp1_valid, bus_f.rsp0_valid, bus_f.rsp0_res, a + b); else n_pass++;
        end
        bus_f.req0_valid = 0;
        bus_f.req1_valid = 0;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        set0(1, 32'd7, 32'd9, 4'd0, 0);
        #1;
        n_chk++; if (bus.req0_ready !== 1'b1) $display("FAIL rmid_hs: got %b want 1", bus.req0_ready); else n_pass++;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.rsp0_valid !== 1'b0 || bus.rsp0_res !== 32'd0 || bus.req0_ready !== 1'b0) $display("FAIL rmid_outputs: got v=%b res=%h rdy=%b want 0", bus.rsp0_valid, bus.rsp0_res, bus.req0_ready); else n_pass++;
        n_chk++; if (bus.alu_clk_en !== 1'b0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) $display("FAIL rmid_alu: got en=%b a=%h b=%h want 0", bus.alu_clk_en, bus.alu_a, bus.alu_b); else n_pass++;
        set0(0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        own = -1;
        last = 1;
        @(posedge clk);
        #1;
        n_chk++; if (bus.rsp0_valid !== 1'b0) $display("FAIL rmid_no_rsp: got %b want 0", bus.rsp0_valid); else n_pass++;
        set0(1, $urandom, $urandom, 4'd0, 0);
        set1(1, $urandom, $urandom, 4'd0, 0);
        #1;
        n_chk++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) $display("FAIL rmid_first_grant: got rdy=%b%b want 01", bus.req1_ready, bus.req0_ready); else n_pass++;
        tick();
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_alu_codes();
        set0(1, 32'hFFFF_FFFF, 32'd1, 4'd3, 0);
        #1;
        n_chk++; if (bus.alu_fn !== 4'd3) $display("FAIL codes_fn_cmplt: got %h want 3", bus.alu_fn); else n_pass++;
        tick();
        n_chk++; if (bus.rsp0_res !== 32'd1) $display("FAIL codes_cmplt: got %h want 1", bus.rsp0_res); else n_pass++;
        set0(1, 32'd100, 32'd5, 4'd4, 0);
        tick();
        n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_res !== 32'd0) $display("FAIL codes_div: got v=%b res=%h want 1 0", bus.rsp0_valid, bus.rsp0_res); else n_pass++;
        set0(1, 32'd3, 32'd3, 4'hF, 0);
        #1;
        n_chk++; if (bus.alu_fn !== 4'hF) $display("FAIL codes_fn_undef: got %h want f", bus.alu_fn); else n_pass++;
        tick();
        n_chk++; if (bus.rsp0_res !== 32'd0) $display("FAIL codes_undef: got %h want 0", bus.rsp0_res); else n_pass++;
        set0(0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        bus_f.req0_valid = 0; bus_f.req0_a = 0; bus_f.req0_b = 0; bus_f.req0_fn = 0; bus_f.req0_lock = 0;
        bus_f.req1_valid = 0; bus_f.req1_a = 0; bus_f.req1_b = 0; bus_f.req1_fn = 0; bus_f.req1_lock = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_lock();
        test_fixed_priority();
        test_reset_mid();
        test_alu_codes();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to port 0.
REQ-002 SHALL have port clk, input, 1, the single clock for the block; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, meaning the requester presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1 each, meaning the operation is accepted this cycle.
REQ-006 SHALL have ports req0_a / req1_a and req0_b / req1_b, input, 32 each, the operands.
REQ-007 SHALL have ports req0_fn / req1_fn, input, 4 each, the ALU function code (opcode 4 LSBs).
REQ-008 SHALL have ports req0_lock / req1_lock, input, 1 each, meaning hold the grant after this operation.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid, output, 1 each, a result pulse.
REQ-010 SHALL have ports rsp0_res / rsp1_res, output, 32 each, the result data.
REQ-011 SHALL have ports alu_clk_en, output, 1; alu_a and alu_b, output, 32 each; alu_fn, output, 4; these drive the shared registered ALU.
REQ-012 SHALL have port alu_res, input, 32, the ALU registered result, valid 1 cycle after alu_clk_en.

Function
REQ-013 SHALL implement states ARB, LOCK0, LOCK1.
REQ-014 In ARB with exactly one valid port, SHALL grant that port.
REQ-015 In ARB with both ports valid, SHALL grant by the round-robin pointer when RR_EN=1, or grant port 0 when RR_EN=0.
REQ-016 Round-robin pointer SHALL point to the port not granted by the last accepted op; its reset value is port 0.
REQ-017 In LOCKn, SHALL grant only port n; the other port's ready SHALL be 0 even if port n is idle.
REQ-018 Transitions:
- ARB->LOCKn on an accepted op from port n with reqn_lock=1.
- LOCKn->ARB on an accepted op from port n with reqn_lock=0.
- Otherwise the state is held.
REQ-019 Grant, ready, alu_a, alu_b and alu_fn SHALL be combinational from the current state, the pointer and the valids; ready SHALL be asserted only for the granted port and only when its valid=1.
REQ-020 alu_clk_en SHALL be 1 exactly in the cycles where a handshake (valid&ready) occurs; when it is 0, alu_a, alu_b and alu_fn SHALL be 0.
REQ-021 On a handshake in cycle N, SHALL register an in-flight tag (valid, port id).
- In cycle N+1, rspX_valid=1 for the tagged port only and rspX_res=alu_res.
- Latency is 1 cycle; throughput is 1 op/cycle.
REQ-022 rspX_res SHALL be 0 whenever rspX_valid=0.
REQ-023 Responses SHALL have no backpressure; a requester must accept the rsp pulse.
REQ-024 Back-to-back ops to alternating ports SHALL each yield a response on the correct port in order, with no bubble.
REQ-025 Function codes SHALL pass through unmodified; DIV and undefined codes are forwarded and return whatever the ALU produces (0).
REQ-026 Dropping valid while in LOCKn SHALL NOT release the lock; only an accepted op with lock=0 releases it.

Reset
REQ-027 While rst_n=0, asynchronously:
- state=ARB, pointer=port 0, in-flight tag cleared.
- All ready, rsp_valid, rsp_res, alu_clk_en, alu_a, alu_b and alu_fn = 0.
REQ-028 An op accepted in the cycle before reset assertion SHALL produce no response after reset; the first grant after reset release follows REQ-014/015 from state ARB.

Verification
REQ-029 Only port 0 valid, a=5, b=3, fn=ADD (0000) -> req0_ready=1, alu_clk_en=1; next cycle rsp0_valid=1, rsp0_res=8, rsp1_valid=0.
REQ-030 Both valid, RR_EN=1, held 4 cycles -> grants alternate 0,1,0,1, and responses alternate ports with 1-cycle latency.
REQ-031 RR_EN=0, both valid 3 cycles -> port 0 granted every cycle and req1_ready stays 0.
REQ-032 Port 1 op with lock=1 (SUB 10-4), then port 0 valid for 3 cycles while port 1 idles -> req0_ready=0 throughout; port 1 op with lock=0 (SHL 1<<4) -> rsp1_res=16, then ARB resumes and port 0 is granted.
REQ-033 Handshake on port 0, then rst_n pulled low mid-cycle -> all outputs 0 immediately, no rsp0_valid after release, state=ARB.
REQ-034 Port 0 fn=CMPLT, a=-1, b=1 -> rsp0_res=1; fn=DIV -> rsp0_res=0.
